mem_stage: RTL and testbench
============================

# mem_stage

Pipeline stage after execute. Consumes the registered EX→MEM bundle and control, runs at most one data-memory access at a time over a request/grant/rvalid interface, and aligns load data and store data. Registers the MEM→WB bundle and WB control. Raises `stall_o` to freeze the upstream stages while an access is outstanding.

## Interface
- Parameters: none. Widths come from `riscv_cpu_pkg` (`DATA_WIDTH` = 32, `REG_ADDR_WIDTH` = 5).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: asynchronous reset, active low.
- `mem_ctl_i` in, `mem_ctl_t`: memory control.
- `wb_ctl_i` in, `wb_ctl_t`: writeback control.
- `mem_pipeline_i` in, `ex2mem_t`: carries `pc`, `branch_addr`, `mem_wdata`, `dest_reg`, `alu_result`. `alu_result` is the access address.
- `stall_o` out, 1: freeze IF/ID/EX registers; upstream holds its inputs stable.
- `data_req_o` out, 1: memory request.
- `data_gnt_i` in, 1: request accepted.
- `data_addr_o` out, 32: word-aligned address.
- `data_we_o` out, 1: write enable.
- `data_be_o` out, 4: byte enables.
- `data_wdata_o` out, 32: lane-aligned store data.
- `data_rvalid_i` in, 1: response valid (reads and writes).
- `data_rdata_i` in, 32: read data.
- `wb_ctl_o` out, `wb_ctl_t`: registered writeback control.
- `wb_pipeline_o` out, `mem2wb_t`: registered `pc`, `alu_result`, `mem_rdata`, `dest_reg`.
- `misaligned_o` out, 1: registered misaligned-access flag.

## Operation
- FSM states: IDLE, REQ, WAIT.
  - IDLE, `mem_ctl_i.mem_req`=0: pass-through. WB registers load the inputs every cycle. `stall_o`=0.
  - IDLE, `mem_req`=1: drive the request combinationally. `gnt`=1 goes to WAIT; `gnt`=0 goes to REQ.
  - REQ: hold `data_req_o`=1 with address, `we`, `be` and `wdata` stable until `gnt`=1, then go to WAIT.
  - WAIT: `data_req_o`=0. On `rvalid`=1, go to IDLE.
- `stall_o`=1 in every cycle of an access except the cycle in which `rvalid` is sampled.
- While `stall_o`=1, the WB registers load a bubble (`wb_ctl` all zero).
- On the `rvalid` cycle, the WB registers capture the instruction, with `mem_rdata` = the extracted load value (0 for stores).
- Registered in REQ→WAIT: byte offset `addr[1:0]`, `mem_size`, `mem_sign_ext`.
- `data_addr_o` = {`alu_result`[31:2], 2'b00}.
- Stores, lanes replicated:
  - SB: `be` = 4'b0001 << off; `wdata` = {4{`wdata`[7:0]}}.
  - SH: `be` = 4'b0011 << (off[1]·2); `wdata` = {2{`wdata`[15:0]}}.
  - SW: `be` = 4'b1111.
- Loads: `be` = 4'b1111. Extract byte/half from `rdata` >> (off·8), then sign- or zero-extend per `mem_sign_ext`.
- Ignored inputs: `rvalid` in IDLE or REQ; `gnt` in WAIT. Only one access is outstanding.
- Reset mid-access: FSM returns to IDLE, all registers clear. A late `rvalid` after reset is ignored.

## Timing
- Reset values:
  - `wb_ctl_o`, `wb_pipeline_o`, `misaligned_o`: all zero.
  - `data_req_o`, `data_we_o`, `data_be_o`, `data_addr_o`, `data_wdata_o`: all 0.
  - `stall_o`: 0.
- Non-memory instruction: 1-cycle latency, input edge to WB register.
- Memory access with immediate `gnt` and `rvalid` on the next cycle: 2 cycles, 1 stall cycle.
- Each extra `gnt` or `rvalid` wait cycle adds one stall cycle.
- Back-to-back accesses: the next request may be issued in the cycle after the `rvalid` cycle.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - Misaligned cases: SH with `addr[0]`=1; SW with `addr[1:0]`≠0.
  - Effect: no request is issued and no stall occurs. WB registers get the instruction with `reg_write` forced to 0. `misaligned_o`=1 for one cycle.
- `MEM_MISALIGN_CHECK_EN` undefined:
  - Low address bits are ignored as required for the size (SW uses off=0; SH uses off[0]=0).
  - `misaligned_o` is tied to 0.

## Structure
- `riscv_cpu_pkg` holds:
  - `mem_ctl_t`: `mem_req`, `mem_we`, `mem_size`[1:0] (`MEM_B`/`MEM_H`/`MEM_W`), `mem_sign_ext`.
  - `mem2wb_t`.
  - The FSM state enum `mem_state_e`.
- One sub-module: `lsu_align`. Combinational store lane/`be` generation and load extraction/extension.

## Test plan
- Non-memory op with `alu_result`=0x1234 → `wb_pipeline_o.alu_result`=0x1234 next cycle; `stall_o` never 1.
- SB at 0x1003 with `wdata`=0xAB, `gnt` same cycle → `data_addr_o`=0x1000, `be`=4'b1000, `wdata_o`=0xABABABAB; `stall_o` high 1 cycle.
- LH signed at 0x2002, `rdata`=0x8001_0000, `gnt` after 2 cycles, `rvalid` 3 cycles later → `mem_rdata`=0xFFFF8001; `stall_o` high 5 cycles; `req` stable during REQ.
- LBU at 0x3001, `rdata`=0x0000_F700 → `mem_rdata`=0x000000F7; spurious `rvalid` in IDLE → no effect.
- `rst_ni` low during WAIT, then `rvalid` → FSM IDLE, all outputs 0, no WB capture.
- SW at 0x4002:
  - With macro: `data_req_o`=0, `misaligned_o`=1, `reg_write`=0.
  - Without macro: `addr`=0x4000, `be`=4'b1111.

Source files
------------

// File: rtl/riscv_cpu_pkg.sv
// Shared types for the RISC-V pipeline: widths, memory control, stage
// bundles and the memory-stage FSM state encoding.
package riscv_cpu_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8;

  // Access size encoding carried in mem_ctl_t.mem_size
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic      mem_req;
    logic      mem_we;
    mem_size_e mem_size;
    logic      mem_sign_ext;
  } mem_ctl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctl_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     branch_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [REG_ADDR_WIDTH-1:0] dest_reg;
    logic [DATA_WIDTH-1:0]     alu_result;
  } ex2mem_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic [REG_ADDR_WIDTH-1:0] dest_reg;
  } mem2wb_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_REQ  = 2'b01,
    MS_WAIT = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational lane steering for the data-memory port.
//   Store side: byte enables and lane-replicated write data from size/offset.
//   Load side : extracts byte/half from the read word and sign/zero-extends.
// Ports:
//   i_st_size, i_st_off, i_st_we, i_st_wdata -> o_be, o_wdata
//   i_ld_size, i_ld_off, i_ld_sign, i_rdata  -> o_ld_data
module lsu_align
  import riscv_cpu_pkg::*;
(
  input  mem_size_e             i_st_size,
  input  logic [1:0]            i_st_off,
  input  logic                  i_st_we,
  input  logic [DATA_WIDTH-1:0] i_st_wdata,
  output logic [BE_WIDTH-1:0]   o_be,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  mem_size_e             i_ld_size,
  input  logic [1:0]            i_ld_off,
  input  logic                  i_ld_sign,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_ld_data
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  // Store lanes; halfwords ignore off[0], words ignore the offset entirely
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = '0;
    if (i_st_we) begin
      case (i_st_size)
        MEM_B: begin
          o_be    = 4'(4'b0001 << i_st_off);
          o_wdata = {4{i_st_wdata[7:0]}};
        end
        MEM_H: begin
          o_be    = 4'(4'b0011 << {i_st_off[1], 1'b0});
          o_wdata = {2{i_st_wdata[15:0]}};
        end
        default: begin
          o_be    = 4'b1111;
          o_wdata = i_st_wdata;
        end
      endcase
    end
  end

  assign w_ld_byte = 8'(i_rdata >> {i_ld_off, 3'b000});
  assign w_ld_half = 16'(i_rdata >> {i_ld_off[1], 4'b0000});

  // Load extraction and extension
  always_comb begin
    o_ld_data = i_rdata;
    case (i_ld_size)
      MEM_B:   o_ld_data = {{24{i_ld_sign & w_ld_byte[7]}}, w_ld_byte};
      MEM_H:   o_ld_data = {{16{i_ld_sign & w_ld_half[15]}}, w_ld_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline stage after execute. Runs at most one data-memory
// access over a req/gnt/rvalid port, aligns store/load data and registers
// the MEM->WB bundle. stall_o freezes upstream while an access is open.
// Ports:
//   clk_i, rst_ni (async, active low)
//   mem_ctl_i, wb_ctl_i, mem_pipeline_i : EX->MEM bundle and control
//   stall_o                             : freeze IF/ID/EX
//   data_req_o/gnt_i/addr_o/we_o/be_o/wdata_o/rvalid_i/rdata_i : memory port
//   wb_ctl_o, wb_pipeline_o             : registered MEM->WB bundle
//   misaligned_o                        : registered misaligned-access flag
// Build option: MEM_MISALIGN_CHECK_EN enables misaligned SH/SW detection;
// when undefined the low address bits are ignored and misaligned_o stays 0.
module mem_stage
  import riscv_cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  mem_ctl_t              mem_ctl_i,
  input  wb_ctl_t               wb_ctl_i,
  input  ex2mem_t               mem_pipeline_i,
  output logic                  stall_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output wb_ctl_t               wb_ctl_o,
  output mem2wb_t               wb_pipeline_o,
  output logic                  misaligned_o
);

  mem_state_e r_state;
  logic [1:0] r_off;
  mem_size_e  r_size;
  logic       r_sign;
  logic       r_we;
  wb_ctl_t    r_wb_ctl;
  mem2wb_t    r_wb_pipe;
  logic       r_misaligned;

  logic                  w_misaligned;
  logic                  w_issue;
  logic                  w_req;
  logic                  w_stall;
  logic                  w_ld_capture;
  logic [BE_WIDTH-1:0]   w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [DATA_WIDTH-1:0] w_addr;
  logic                  w_unused_branch;

  assign w_addr = mem_pipeline_i.alu_result;

  // Branch target is not consumed in this stage
  assign w_unused_branch = ^mem_pipeline_i.branch_addr;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misaligned = (r_state == MS_IDLE) & mem_ctl_i.mem_req &
                        (((mem_ctl_i.mem_size == MEM_H) & w_addr[0]) |
                         ((mem_ctl_i.mem_size == MEM_W) & (w_addr[1:0] != 2'b00)));
`else
  assign w_misaligned = 1'b0;
`endif

  // Request is driven combinationally from IDLE so an immediate grant costs no cycle
  assign w_issue = (r_state == MS_IDLE) & mem_ctl_i.mem_req & ~w_misaligned;
  assign w_req   = w_issue | (r_state == MS_REQ);

  // Stall covers the whole access except the cycle rvalid is sampled
  assign w_stall      = w_req | ((r_state == MS_WAIT) & ~data_rvalid_i);
  assign w_ld_capture = (r_state == MS_WAIT) & ~r_we;

  lsu_align u_lsu_align (
    .i_st_size  (mem_ctl_i.mem_size),
    .i_st_off   (w_addr[1:0]),
    .i_st_we    (mem_ctl_i.mem_we),
    .i_st_wdata (mem_pipeline_i.mem_wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_size  (r_size),
    .i_ld_off   (r_off),
    .i_ld_sign  (r_sign),
    .i_rdata    (data_rdata_i),
    .o_ld_data  (w_ld_data)
  );

  // Memory port is quiet (all zero) whenever no request is presented
  assign data_req_o   = w_req;
  assign data_addr_o  = w_req ? {w_addr[DATA_WIDTH-1:2], 2'b00} : '0;
  assign data_we_o    = w_req & mem_ctl_i.mem_we;
  assign data_be_o    = w_req ? w_be : '0;
  assign data_wdata_o = w_req ? w_wdata : '0;
  assign stall_o      = w_stall;

  assign wb_ctl_o      = r_wb_ctl;
  assign wb_pipeline_o = r_wb_pipe;
  assign misaligned_o  = r_misaligned;

  // Access FSM, grant-time capture of load shaping, and WB registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= MS_IDLE;
      r_off        <= 2'b00;
      r_size       <= MEM_B;
      r_sign       <= 1'b0;
      r_we         <= 1'b0;
      r_wb_ctl     <= '0;
      r_wb_pipe    <= '0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        MS_IDLE: if (w_issue)       r_state <= data_gnt_i ? MS_WAIT : MS_REQ;
        MS_REQ:  if (data_gnt_i)    r_state <= MS_WAIT;
        MS_WAIT: if (data_rvalid_i) r_state <= MS_IDLE;
        default:                    r_state <= MS_IDLE;
      endcase

      if (w_req & data_gnt_i) begin
        r_off  <= w_addr[1:0];
        r_size <= mem_ctl_i.mem_size;
        r_sign <= mem_ctl_i.mem_sign_ext;
        r_we   <= mem_ctl_i.mem_we;
      end

      if (w_stall) begin
        r_wb_ctl     <= '0;
        r_wb_pipe    <= '0;
        r_misaligned <= 1'b0;
      end else begin
        r_wb_ctl.reg_write       <= wb_ctl_i.reg_write & ~w_misaligned;
        r_wb_ctl.mem_to_reg      <= wb_ctl_i.mem_to_reg;
        r_wb_pipe.pc             <= mem_pipeline_i.pc;
        r_wb_pipe.alu_result     <= mem_pipeline_i.alu_result;
        r_wb_pipe.dest_reg       <= mem_pipeline_i.dest_reg;
        r_wb_pipe.mem_rdata      <= w_ld_capture ? w_ld_data : '0;
        r_misaligned             <= w_misaligned;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, stores, loads with grant and
// response waits, spurious responses, reset mid-access, back-to-back access.
module tb_mem_stage;
  import riscv_cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  mem_ctl_t    mem_ctl;
  wb_ctl_t     wb_ctl;
  ex2mem_t     ex;
  logic        stall;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  wb_ctl_t     wb_ctl_out;
  mem2wb_t     wb_pipe_out;
  logic        misaligned;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_ctl_i      (mem_ctl),
    .wb_ctl_i       (wb_ctl),
    .mem_pipeline_i (ex),
    .stall_o        (stall),
    .data_req_o     (data_req),
    .data_gnt_i     (data_gnt),
    .data_addr_o    (data_addr),
    .data_we_o      (data_we),
    .data_be_o      (data_be),
    .data_wdata_o   (data_wdata),
    .data_rvalid_i  (data_rvalid),
    .data_rdata_i   (data_rdata),
    .wb_ctl_o       (wb_ctl_out),
    .wb_pipeline_o  (wb_pipe_out),
    .misaligned_o   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop(input logic [31:0] alu, input logic rw);
    mem_ctl.mem_req      = 1'b0;
    mem_ctl.mem_we       = 1'b0;
    mem_ctl.mem_size     = MEM_B;
    mem_ctl.mem_sign_ext = 1'b0;
    wb_ctl.reg_write     = rw;
    wb_ctl.mem_to_reg    = 1'b0;
    ex.pc                = 32'h0000_0100;
    ex.branch_addr       = 32'h0;
    ex.mem_wdata         = 32'h0;
    ex.dest_reg          = 5'd3;
    ex.alu_result        = alu;
  endtask

  task automatic set_mem(input logic we, input mem_size_e sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic rw, input logic [4:0] dest);
    mem_ctl.mem_req      = 1'b1;
    mem_ctl.mem_we       = we;
    mem_ctl.mem_size     = sz;
    mem_ctl.mem_sign_ext = sgn;
    wb_ctl.reg_write     = rw;
    wb_ctl.mem_to_reg    = ~we;
    ex.pc                = 32'h0000_0200;
    ex.branch_addr       = 32'h0000_0abc;
    ex.mem_wdata         = wd;
    ex.dest_reg          = dest;
    ex.alu_result        = addr;
  endtask

  // Plays the memory side of one access starting at posedge+1 with the
  // instruction already applied; returns after the WB capture edge.
  task automatic do_access(input int gnt_wait, input int rv_wait,
                           input logic [31:0] rdata, output int stalls,
                           output int req_bad, output bit timeout);
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    bit          done;
    stalls  = 0;
    req_bad = 0;
    timeout = 1'b1;
    done    = 1'b0;
    a0 = '0; w0 = '0; b0 = '0;
    for (int k = 0; k < 40; k++) begin
      data_gnt    = (k == gnt_wait);
      data_rvalid = (k == gnt_wait + rv_wait);
      data_rdata  = data_rvalid ? rdata : 32'hA5A5_A5A5;
      #1;
      if (stall) stalls++;
      if (k == 0) begin
        a0 = data_addr; b0 = data_be; w0 = data_wdata;
      end
      if (k <= gnt_wait) begin
        if (data_req !== 1'b1 || data_addr !== a0 || data_be !== b0 || data_wdata !== w0)
          req_bad++;
      end else if (data_req !== 1'b0) begin
        req_bad++;
      end
      done = data_rvalid;
      tick();
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
    data_gnt    = 1'b0;
    data_rvalid = 1'b0;
    data_rdata  = 32'h0;
    mem_ctl.mem_req  = 1'b0;
    wb_ctl.reg_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0;
    set_nop(32'h0, 1'b1);
    #12;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_cmp++; if ({data_req, data_we, data_be, data_addr, data_wdata} !== '0) begin
      n_bad++; $display("FAIL reset_port got req=%b we=%b be=%h addr=%h wd=%h exp all 0",
                        data_req, data_we, data_be, data_addr, data_wdata); end
    n_cmp++; if (wb_ctl_out !== '0 || wb_pipe_out !== '0) begin
      n_bad++; $display("FAIL reset_wb got ctl=%h pipe=%h exp 0", wb_ctl_out, wb_pipe_out); end
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL reset_mis got %b exp 0", misaligned); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_passthru();
    set_nop(32'h0000_1234, 1'b1);
    #1;
    n_cmp++; if (stall !== 1'b0 || data_req !== 1'b0) begin
      n_bad++; $display("FAIL pass_comb got stall=%b req=%b exp 0 0", stall, data_req); end
    tick();
    n_cmp++; if (wb_pipe_out.alu_result !== 32'h0000_1234) begin
      n_bad++; $display("FAIL pass_alu got %h exp 00001234", wb_pipe_out.alu_result); end
    n_cmp++; if (wb_pipe_out.pc !== 32'h100 || wb_pipe_out.dest_reg !== 5'd3 || wb_ctl_out.reg_write !== 1'b1) begin
      n_bad++; $display("FAIL pass_fields got pc=%h rd=%0d rw=%b exp 100 3 1",
                        wb_pipe_out.pc, wb_pipe_out.dest_reg, wb_ctl_out.reg_write); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL pass_stall got %b exp 0", stall); end
  endtask

  task automatic test_sb();
    int s, rb; bit to;
    set_mem(1'b1, MEM_B, 1'b0, 32'h0000_1003, 32'h0000_00AB, 1'b0, 5'd0);
    #1;
    n_cmp++; if (data_req !== 1'b1 || data_we !== 1'b1 || data_addr !== 32'h1000) begin
      n_bad++; $display("FAIL sb_req got req=%b we=%b addr=%h exp 1 1 00001000", data_req, data_we, data_addr); end
    n_cmp++; if (data_be !== 4'b1000 || data_wdata !== 32'hABAB_ABAB) begin
      n_bad++; $display("FAIL sb_lanes got be=%b wd=%h exp 1000 abababab", data_be, data_wdata); end
    do_access(0, 1, 32'hFFFF_FFFF, s, rb, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL sb_timeout got timeout exp rvalid"); end
    n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL sb_stalls got %0d exp 1", s); end
    n_cmp++; if (wb_pipe_out.mem_rdata !== 32'h0 || wb_pipe_out.alu_result !== 32'h1003) begin
      n_bad++; $display("FAIL sb_wb got rdata=%h alu=%h exp 0 1003", wb_pipe_out.mem_rdata, wb_pipe_out.alu_result); end
  endtask

  task automatic test_lh_waits();
    int s, rb; bit to;
    set_mem(1'b0, MEM_H, 1'b1, 32'h0000_2002, 32'h0, 1'b1, 5'd7);
    #1;
    n_cmp++; if (data_be !== 4'b1111 || data_addr !== 32'h2000 || data_we !== 1'b0) begin
      n_bad++; $display("FAIL lh_req got be=%b addr=%h we=%b exp 1111 2000 0", data_be, data_addr, data_we); end
    do_access(2, 3, 32'h8001_0000, s, rb, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL lh_timeout got timeout exp rvalid"); end
    n_cmp++; if (s !== 5) begin n_bad++; $display("FAIL lh_stalls got %0d exp 5", s); end
    n_cmp++; if (rb !== 0) begin n_bad++; $display("FAIL lh_req_stable got %0d bad cycles exp 0", rb); end
    n_cmp++; if (wb_pipe_out.mem_rdata !== 32'hFFFF_8001) begin
      n_bad++; $display("FAIL lh_rdata got %h exp ffff8001", wb_pipe_out.mem_rdata); end
    n_cmp++; if (wb_ctl_out.reg_write !== 1'b1 || wb_ctl_out.mem_to_reg !== 1'b1 || wb_pipe_out.dest_reg !== 5'd7) begin
      n_bad++; $display("FAIL lh_ctl got rw=%b m2r=%b rd=%0d exp 1 1 7",
                        wb_ctl_out.reg_write, wb_ctl_out.mem_to_reg, wb_pipe_out.dest_reg); end
  endtask

  task automatic test_lbu_spurious();
    int s, rb; bit to;
    set_nop(32'h0000_3000, 1'b1);
    data_rvalid = 1'b1; data_rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (stall !== 1'b0 || data_req !== 1'b0) begin
      n_bad++; $display("FAIL spur_comb got stall=%b req=%b exp 0 0", stall, data_req); end
    tick();
    data_rvalid = 1'b0;
    n_cmp++; if (wb_pipe_out.mem_rdata !== 32'h0 || wb_pipe_out.alu_result !== 32'h3000) begin
      n_bad++; $display("FAIL spur_wb got rdata=%h alu=%h exp 0 3000", wb_pipe_out.mem_rdata, wb_pipe_out.alu_result); end
    set_mem(1'b0, MEM_B, 1'b0, 32'h0000_3001, 32'h0, 1'b1, 5'd9);
    do_access(1, 1, 32'h0000_F700, s, rb, to);
    n_cmp++; if (to || s !== 2) begin n_bad++; $display("FAIL lbu_stalls got %0d to=%b exp 2 0", s, to); end
    n_cmp++; if (wb_pipe_out.mem_rdata !== 32'h0000_00F7) begin
      n_bad++; $display("FAIL lbu_rdata got %h exp 000000f7", wb_pipe_out.mem_rdata); end
  endtask

  task automatic test_reset_mid_access();
    set_nop(32'h0000_0077, 1'b1);
    tick();
    n_cmp++; if (wb_ctl_out.reg_write !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre got rw=%b exp 1", wb_ctl_out.reg_write); end
    set_mem(1'b0, MEM_W, 1'b0, 32'h0000_7000, 32'h0, 1'b1, 5'd4);
    data_gnt = 1'b1;
    tick();
    data_gnt = 1'b0;
    n_cmp++; if (wb_ctl_out !== '0 || stall !== 1'b1) begin
      n_bad++; $display("FAIL rst_bubble got ctl=%h stall=%b exp 0 1", wb_ctl_out, stall); end
    rst_n = 1'b0;
    set_nop(32'h0000_0055, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0 || data_req !== 1'b0 || wb_pipe_out !== '0 || wb_ctl_out !== '0) begin
      n_bad++; $display("FAIL rst_mid got stall=%b req=%b pipe=%h ctl=%h exp all 0",
                        stall, data_req, wb_pipe_out, wb_ctl_out); end
    tick();
    rst_n = 1'b1;
    set_nop(32'h0000_0055, 1'b1);
    data_rvalid = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (stall !== 1'b0 || data_req !== 1'b0) begin
      n_bad++; $display("FAIL rst_late_comb got stall=%b req=%b exp 0 0", stall, data_req); end
    tick();
    data_rvalid = 1'b0;
    n_cmp++; if (wb_pipe_out.mem_rdata !== 32'h0 || wb_pipe_out.alu_result !== 32'h55 || wb_ctl_out.reg_write !== 1'b1) begin
      n_bad++; $display("FAIL rst_late_wb got rdata=%h alu=%h rw=%b exp 0 55 1",
                        wb_pipe_out.mem_rdata, wb_pipe_out.alu_result, wb_ctl_out.reg_write); end
  endtask

  task automatic test_sw_misaligned();
    int s, rb; bit to;
    set_mem(1'b1, MEM_W, 1'b0, 32'h0000_4002, 32'hCAFE_F00D, 1'b1, 5'd6);
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    n_cmp++; if (data_req !== 1'b0 || stall !== 1'b0) begin
      n_bad++; $display("FAIL sw_mis_comb got req=%b stall=%b exp 0 0", data_req, stall); end
    tick();
    n_cmp++; if (misaligned !== 1'b1 || wb_ctl_out.reg_write !== 1'b0 || wb_pipe_out.alu_result !== 32'h4002) begin
      n_bad++; $display("FAIL sw_mis_wb got mis=%b rw=%b alu=%h exp 1 0 4002",
                        misaligned, wb_ctl_out.reg_write, wb_pipe_out.alu_result); end
    set_nop(32'h0, 1'b0);
    tick();
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL sw_mis_pulse got %b exp 0", misaligned); end
`else
    n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h4000 || data_be !== 4'b1111 || data_wdata !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL sw_req got req=%b addr=%h be=%b wd=%h exp 1 4000 1111 cafef00d",
                        data_req, data_addr, data_be, data_wdata); end
    do_access(0, 1, 32'h0, s, rb, to);
    n_cmp++; if (to || s !== 1 || misaligned !== 1'b0) begin
      n_bad++; $display("FAIL sw_done got stalls=%0d to=%b mis=%b exp 1 0 0", s, to, misaligned); end
`endif
  endtask

  task automatic test_back_to_back();
    int s, rb; bit to;
    set_mem(1'b0, MEM_W, 1'b0, 32'h0000_5000, 32'h0, 1'b1, 5'd10);
    do_access(0, 1, 32'h1122_3344, s, rb, to);
    n_cmp++; if (to || wb_pipe_out.mem_rdata !== 32'h1122_3344) begin
      n_bad++; $display("FAIL b2b_lw got %h to=%b exp 11223344 0", wb_pipe_out.mem_rdata, to); end
    set_mem(1'b1, MEM_H, 1'b0, 32'h0000_5002, 32'h1234_BEEF, 1'b0, 5'd0);
    #1;
    n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h5000 || data_be !== 4'b1100 || data_wdata !== 32'hBEEF_BEEF) begin
      n_bad++; $display("FAIL b2b_sh got req=%b addr=%h be=%b wd=%h exp 1 5000 1100 beefbeef",
                        data_req, data_addr, data_be, data_wdata); end
    do_access(0, 1, 32'hFFFF_FFFF, s, rb, to);
    n_cmp++; if (to || s !== 1 || wb_pipe_out.mem_rdata !== 32'h0) begin
      n_bad++; $display("FAIL b2b_sh_done got stalls=%0d rdata=%h exp 1 0", s, wb_pipe_out.mem_rdata); end
    set_mem(1'b0, MEM_B, 1'b1, 32'h0000_6003, 32'h0, 1'b1, 5'd11);
    do_access(0, 2, 32'h8000_0000, s, rb, to);
    n_cmp++; if (to || s !== 2 || wb_pipe_out.mem_rdata !== 32'hFFFF_FF80) begin
      n_bad++; $display("FAIL b2b_lb got stalls=%0d rdata=%h exp 2 ffffff80", s, wb_pipe_out.mem_rdata); end
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_sb();
    test_lh_waits();
    test_lbu_spurious();
    test_reset_mid_access();
    test_sw_misaligned();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
